inspection_feeder: RTL

INSPECTION_FEEDER -- requirements
Module: inspection_feeder

---
 rtl/insp_pkg.sv | 19 +
 rtl/verdict_fifo.sv | 52 +++++
 rtl/inspection_feeder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/insp_pkg.sv
// insp_pkg: shared types for the inspection feeder.
// Holds the E status codes and the feeder FSM state enum.
package insp_pkg;

  localparam logic [1:0] E_IDLE = 2'b00;
  localparam logic [1:0] E_INSP = 2'b01;
  localparam logic [1:0] E_PASS = 2'b10;
  localparam logic [1:0] E_FAIL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESENT,
    S_RESULT,
    S_WAIT_DONE,
    S_RELEASE,
    S_ERROR
  } feeder_state_t;

endpackage

// File: rtl/verdict_fifo.sv
// verdict_fifo: 1-bit wide queue of expected verdicts.
// ready drops when full, even if a pop happens that cycle.
module verdict_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic ready,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign ready   = (count != (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  // storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/inspection_feeder.sv
// inspection_feeder: queues expected verdicts and drives the inspector.
// Optional verdict check enabled by FEEDER_MISMATCH_CHK_EN.
import insp_pkg::*;

module inspection_feeder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic             load_bit,
  output logic             load_ready,
  input  logic [1:0]       E,
  output logic             P,
  output logic             RI,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             mismatch,
  output logic             timeout_err,
  input  logic             clr_err
);

  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  feeder_state_t state_q, state_d;
  logic [WW-1:0] wait_cnt;
  logic exp_q, exp_d;
  logic pop, empty, head;
  logic inc_pass, inc_fail, set_to;
  logic timed_out;

  verdict_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (load_valid),
    .din   (load_bit),
    .pop   (pop),
    .ready (load_ready),
    .empty (empty),
    .head  (head)
  );

  assign timed_out = (wait_cnt == TO_LAST);

  // next state and event strobes
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    pop      = 1'b0;
    inc_pass = 1'b0;
    inc_fail = 1'b0;
    set_to   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && E == E_IDLE) begin
          state_d = S_PRESENT;
          pop     = 1'b1;
          exp_d   = head;
        end
      end
      S_PRESENT: begin
        if (E == E_INSP) begin
          state_d = S_RESULT;
        end else if (timed_out) begin
          state_d = S_ERROR;
          set_to  = 1'b1;
        end
      end
      S_RESULT: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (E == E_PASS) begin
          inc_pass = 1'b1;
          state_d  = S_RELEASE;
        end else if (E == E_FAIL) begin
          inc_fail = 1'b1;
          state_d  = S_RELEASE;
        end else if (timed_out) begin
          state_d = S_ERROR;
          set_to  = 1'b1;
        end
      end
      S_RELEASE: begin
        if (E == E_IDLE) begin
          state_d = S_IDLE;
        end else if (timed_out) begin
          state_d = S_ERROR;
          set_to  = 1'b1;
        end
      end
      S_ERROR: begin
        if (E == E_IDLE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, wait timer and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      exp_q    <= 1'b0;
      wait_cnt <= '0;
      P        <= 1'b0;
      RI       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (!timed_out)
        wait_cnt <= wait_cnt + 1'b1;
      P  <= (state_d == S_PRESENT) ||
            (state_d == S_RESULT)  ||
            (state_d == S_WAIT_DONE);
      RI <= exp_d && ((state_d == S_RESULT) ||
                      (state_d == S_WAIT_DONE));
      busy <= (state_d != S_IDLE);
    end
  end

  // saturating counters and timeout flag, clear wins
  always_ff @(posedge clk) begin
    if (!rst || clr_err) begin
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (inc_pass && pass_cnt != CNT_MAX)
        pass_cnt <= pass_cnt + 1'b1;
      if (inc_fail && fail_cnt != CNT_MAX)
        fail_cnt <= fail_cnt + 1'b1;
      if (set_to)
        timeout_err <= 1'b1;
    end
  end

`ifdef FEEDER_MISMATCH_CHK_EN
  // sticky flag when the inspector disagrees with the queued verdict
  always_ff @(posedge clk) begin
    if (!rst || clr_err)
      mismatch <= 1'b0;
    else if ((inc_pass || inc_fail) && (inc_pass != exp_q))
      mismatch <= 1'b1;
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule
